switch_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the switch PIO slave; its debounced output drives the PIO's in_port.
- Synchronises raw DE1-SoC slide-switch pins into the clk domain and debounces each bit independently with a per-bit stability counter.
- Flags any debounced change with a one-cycle pulse, so software reading the PIO sees only clean, settled values.

---
 rtl/switch_debounce.sv | 85 ++++++++
 tb/tb_switch_debounce.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Slide-switch conditioner: two-flop synchroniser plus per-bit stability-counter debouncer.
// Define SWITCH_DEBOUNCE_EDGE_FLAGS_EN to add per-bit rise_pulse/fall_pulse outputs.
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic             change_pulse
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
    ,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] sw_next;

    // NOTE: registers use non-blocking assignments so sync2 samples the old sync1, not this edge's.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // A bit is accepted only after sync2 has differed from sw_out on DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit; a missed branch would infer a latch.
        sw_next = sw_out;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != sw_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    sw_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the counter array is plain flops, not RAM, so it is reset; no partial count may survive.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            sw_out       <= '0;
            change_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            sw_out       <= sw_next;
            change_pulse <= |(sw_next ^ sw_out);
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
    // Edge flags come from the same next/current pair, so they line up with change_pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= sw_next & ~sw_out;
            fall_pulse <= ~sw_next & sw_out;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (WIDTH=8, DEBOUNCE_CYCLES=4) against a sample-history model.
// Build with SWITCH_DEBOUNCE_EDGE_FLAGS_EN defined to also cover rise_pulse/fall_pulse.
module tb_switch_debounce;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sw_raw;
    logic [7:0] sw_out;
    logic       change_pulse;
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic [7:0] last_rise;
    logic [7:0] last_fall;
`endif

    int compared   = 0;
    int mismatched = 0;
    int pulse_cnt  = 0;

    // Model state: raw value sampled at each clock edge since reset release.
    logic [7:0] raw_q[$];
    logic [7:0] exp_sw;
    logic       exp_pulse;
    logic [7:0] exp_rise;
    logic [7:0] exp_fall;

    switch_debounce #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_raw(sw_raw),
        .sw_out(sw_out),
        .change_pulse(change_pulse)
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
        ,
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // The level the debouncer compares against at edge m is the raw value sampled two edges earlier.
    function automatic logic [7:0] seen_at(input int m);
        if (m < 2) return 8'h00;
        return raw_q[m-2];
    endfunction

    // A bit flips once its last D observed levels all disagree with the current output.
    task automatic model_edge();
        int         n;
        logic [7:0] nxt;
        logic [7:0] s;
        bit         all_diff;
        n   = raw_q.size() - 1;
        nxt = exp_sw;
        for (int i = 0; i < 8; i++) begin
            all_diff = 1'b1;
            for (int m = n - D + 1; m <= n; m++) begin
                s = seen_at(m);
                if (s[i] == exp_sw[i]) all_diff = 1'b0;
            end
            if (all_diff) nxt[i] = ~exp_sw[i];
        end
        exp_pulse = |(nxt ^ exp_sw);
        exp_rise  = nxt & ~exp_sw;
        exp_fall  = ~nxt & exp_sw;
        exp_sw    = nxt;
    endtask

    task automatic model_reset();
        raw_q.delete();
        exp_sw    = 8'h00;
        exp_pulse = 1'b0;
        exp_rise  = 8'h00;
        exp_fall  = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        raw_q.push_back(sw_raw);
        model_edge();
        #1;
        check("sw_out", 32'(sw_out), 32'(exp_sw));
        check("change_pulse", 32'(change_pulse), 32'(exp_pulse));
        if (change_pulse === 1'b1) pulse_cnt++;
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
        check("rise_pulse", 32'(rise_pulse), 32'(exp_rise));
        check("fall_pulse", 32'(fall_pulse), 32'(exp_fall));
        if (change_pulse === 1'b1) begin
            last_rise = rise_pulse;
            last_fall = fall_pulse;
        end
`endif
    endtask

    // Hold the current raw value, measure edges until sw_out reaches val, and expect one pulse overall.
    task automatic settle(input logic [7:0] val, input int exp_lat, input string tag);
        int lat;
        lat = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (lat < 0 && sw_out === val) lat = t;
            if (lat > 0 && t >= lat + 3) break;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " pulses"}, 32'(pulse_cnt), 32'd1);
        check({tag, " value"}, 32'(sw_out), 32'(val));
    endtask

    initial begin
        reset_n = 1'b0;
        sw_raw  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset sw_out", 32'(sw_out), 32'h0);
        check("reset change_pulse", 32'(change_pulse), 32'h0);
        reset_n = 1'b1;

        // Quiet inputs after reset: nothing may move.
        pulse_cnt = 0;
        repeat (20) tick();
        check("idle pulses", 32'(pulse_cnt), 32'd0);

        // Single bit: first sampled at edge k, visible from edge k+5.
        pulse_cnt = 0;
        sw_raw    = 8'h01;
        settle(8'h01, 6, "bit0 rise");

        // Bit 3 bounces with a 2-cycle dwell before holding high.
        pulse_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            sw_raw = 8'h09;
            repeat (2) tick();
            sw_raw = 8'h01;
            repeat (2) tick();
        end
        check("bounce no change", 32'(sw_out), 32'h01);
        sw_raw = 8'h09;
        settle(8'h09, 6, "bit3 bounce");

        pulse_cnt = 0;
        sw_raw    = 8'h00;
        settle(8'h00, 6, "clear");

        // Several bits settling together give one pulse.
        pulse_cnt = 0;
        sw_raw    = 8'hA5;
        settle(8'hA5, 6, "multi A5");

        // Reset asserted mid-count, away from the clock edge.
        sw_raw = 8'hFF;
        repeat (3) tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset sw_out", 32'(sw_out), 32'h0);
        check("midreset change_pulse", 32'(change_pulse), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        pulse_cnt = 0;
        settle(8'hFF, 6, "post reset FF");

        // Mixed rise and fall on one edge.
        pulse_cnt = 0;
        sw_raw    = 8'h0F;
        settle(8'h0F, 6, "to 0F");
        pulse_cnt = 0;
        sw_raw    = 8'hF0;
        settle(8'hF0, 6, "0F to F0");
`ifdef SWITCH_DEBOUNCE_EDGE_FLAGS_EN
        check("edge rise", 32'(last_rise), 32'hF0);
        check("edge fall", 32'(last_fall), 32'h0F);
`endif

        // Random bounce pattern with dwell times straddling the debounce window.
        for (int r = 0; r < 60; r++) begin
            sw_raw = sw_raw ^ 8'($urandom);
            repeat ($urandom_range(1, 7)) tick();
        end
        repeat (10) tick();
        check("random final", 32'(sw_out), 32'(sw_raw));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
